// File: rtl/float_align_pkg.sv
// Shared widths, limits and FSM encoding for the float_align operand aligner.
package float_align_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned MANT_W    = FRAC_W + 1;   // {hidden, fraction}
  localparam int unsigned EXT_W     = 27;           // {hidden, fraction, guard, round, sticky}
  localparam int unsigned WORD_W    = 1 + EXP_W + FRAC_W;
  localparam int unsigned MAX_SHIFT = 27;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Denormals and zero behave as exponent 1 with a cleared hidden bit.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : e;
  endfunction

  function automatic logic hidden_bit(input logic [EXP_W-1:0] e);
    return |e;
  endfunction

endpackage

// File: rtl/float_mag_order.sv
// Combinational magnitude ordering of two single-precision operands.
// swap=1 means B is the larger magnitude; ties keep A as the larger one.
// diff is the effective-exponent distance, larger minus smaller.
module float_mag_order
  import float_align_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              swap,
  output logic [EXP_W-1:0]  diff
);

  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;

  // Compare {exp, fraction} as unsigned and subtract effective exponents.
  always_comb begin
    ea   = eff_exp(A[WORD_W-2:FRAC_W]);
    eb   = eff_exp(B[WORD_W-2:FRAC_W]);
    swap = (B[WORD_W-2:0] > A[WORD_W-2:0]);
    diff = swap ? (eb - ea) : (ea - eb);
  end

endmodule

// File: rtl/float_align.sv
// Floating-point operand aligner: orders A/B by magnitude, then shifts the
// smaller mantissa right one bit per cycle until exponents match.
// Build option: define FLOAT_ALIGN_STICKY_EN to fold shifted-out bits into bit0.
module float_align
  import float_align_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              big_sign,
  output logic              small_sign,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] big_mant,
  output logic [EXT_W-1:0]  small_mant,
  output logic              special
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               swap;
  logic [EXP_W-1:0]   diff;
  logic [WORD_W-1:0]  big_w;
  logic [WORD_W-1:0]  small_w;
  logic               special_w;
  logic [CNT_W-1:0]   cnt_init;
  logic [EXT_W-1:0]   shifted;

  float_mag_order u_order (
    .A    (A),
    .B    (B),
    .swap (swap),
    .diff (diff)
  );

  // Select ordered operands and the saturated shift count for a new pair.
  always_comb begin
    big_w     = swap ? B : A;
    small_w   = swap ? A : B;
    special_w = (&A[WORD_W-2:FRAC_W]) | (&B[WORD_W-2:FRAC_W]);
    if (special_w)
      cnt_init = '0;
    else if (diff > EXP_W'(MAX_SHIFT))
      cnt_init = CNT_W'(MAX_SHIFT);
    else
      cnt_init = diff[CNT_W-1:0];
  end

  // One-bit right shift of the smaller mantissa.
  always_comb begin
`ifdef FLOAT_ALIGN_STICKY_EN
    shifted = {1'b0, small_mant[EXT_W-1:2], small_mant[1] | small_mant[0]};
`else
    shifted = {1'b0, small_mant[EXT_W-1:1]};
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = (cnt_init == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt <= CNT_W'(1))
          state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture and per-cycle alignment shift; fields hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      exp_out    <= '0;
      big_mant   <= '0;
      small_mant <= '0;
      special    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cnt        <= cnt_init;
            big_sign   <= big_w[WORD_W-1];
            small_sign <= small_w[WORD_W-1];
            exp_out    <= eff_exp(big_w[WORD_W-2:FRAC_W]);
            big_mant   <= {hidden_bit(big_w[WORD_W-2:FRAC_W]), big_w[FRAC_W-1:0]};
            small_mant <= {hidden_bit(small_w[WORD_W-2:FRAC_W]), small_w[FRAC_W-1:0], 3'b000};
            special    <= special_w;
          end
        end
        ST_SHIFT: begin
          small_mant <= shifted;
          cnt        <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_align.sv
// Self-checking bench for float_align: directed operand pairs, a behavioural
// alignment model, a per-cycle output compare process and literal pins.
module tb_float_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic        big_sign;
  logic        small_sign;
  logic [7:0]  exp_out;
  logic [23:0] big_mant;
  logic [26:0] small_mant;
  logic        special;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        bs;
    logic        ss;
    logic [7:0]  e;
    logic [23:0] bm;
    logic [26:0] sm;
    logic        sp;
    int          lat;
  } exp_t;

  exp_t exp_cur;
  logic exp_live = 1'b0;

  float_align dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_sign   (big_sign),
    .small_sign (small_sign),
    .exp_out    (exp_out),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .special    (special)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Alignment result from arithmetic on the operand fields.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [31:0] bg;
    logic [31:0] sl;
    int          eb, es, d, s;
    longint      m, lost;
    if (b[30:0] > a[30:0]) begin bg = b; sl = a; end
    else                   begin bg = a; sl = b; end
    eb   = (bg[30:23] == 8'd0) ? 1 : int'(bg[30:23]);
    es   = (sl[30:23] == 8'd0) ? 1 : int'(sl[30:23]);
    r.sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    d    = eb - es;
    s    = r.sp ? 0 : ((d > 27) ? 27 : d);
    m    = ((sl[30:23] != 8'd0) ? (longint'(1) << 26) : 0) + (longint'(sl[22:0]) << 3);
    lost = m & ((longint'(1) << s) - 1);
    m    = m >> s;
`ifdef FLOAT_ALIGN_STICKY_EN
    if (lost != 0) m = m | 1;
`endif
    r.bs  = bg[31];
    r.ss  = sl[31];
    r.e   = 8'(eb);
    r.bm  = ((bg[30:23] != 8'd0) ? 24'h800000 : 24'h0) | {1'b0, bg[22:0]};
    r.sm  = m[26:0];
    r.lat = 1 + s;
    return r;
  endfunction

  // Every cycle a result is presented, it must match the model and block input.
  always @(negedge clk) begin
    if (!rst && out_valid && exp_live) begin
      chk("big_sign",   {31'd0, big_sign},   {31'd0, exp_cur.bs});
      chk("small_sign", {31'd0, small_sign}, {31'd0, exp_cur.ss});
      chk("exp_out",    {24'd0, exp_out},    {24'd0, exp_cur.e});
      chk("big_mant",   {8'd0, big_mant},    {8'd0, exp_cur.bm});
      chk("small_mant", {5'd0, small_mant},  {5'd0, exp_cur.sm});
      chk("special",    {31'd0, special},    {31'd0, exp_cur.sp});
      chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    end
  end

  // Send one pair, check latency, hold DONE for 'hold' cycles, then release.
  task automatic do_pair(input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [26:0] sm_o, output logic [7:0] e_o);
    int lat;
    bit seen;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    exp_cur  = model(a, b);
    exp_live = 1'b1;
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
      @(posedge clk);
    end
    if (!seen) begin
      chk("timeout_out_valid", 32'd0, 32'd1);
      sm_o = 'x; e_o = 'x;
      return;
    end
    chk("latency", lat, exp_cur.lat);
    sm_o = small_mant;
    e_o  = exp_out;
    for (int i = 0; i < hold; i++) begin
      // Offer an unrelated pair while busy; it must not disturb the result.
      A = 32'h12345678; B = 32'h9ABCDEF0; in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    exp_live = 1'b0;
  endtask

  logic [26:0] sm;
  logic [7:0]  e;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_small_mant", {5'd0, small_mant}, 32'd0);
    chk("rst_exp_out",   {24'd0, exp_out},   32'd0);
    rst = 1'b0;

    do_pair(32'h40000000, 32'h3F800000, 0, sm, e);
    chk("lit026_sm", {5'd0, sm}, 32'h2000000);
    chk("lit026_e",  {24'd0, e}, 32'h80);

    do_pair(32'h3F800000, 32'hC0000000, 0, sm, e);
    chk("lit027_sm", {5'd0, sm}, 32'h2000000);

    do_pair(32'h3F800000, 32'h3F800000, 0, sm, e);
    chk("lit028_sm", {5'd0, sm}, 32'h4000000);

    do_pair(32'h4B000000, 32'h3F800001, 0, sm, e);
`ifdef FLOAT_ALIGN_STICKY_EN
    chk("lit029a_sm", {5'd0, sm}, 32'h9);
`else
    chk("lit029a_sm", {5'd0, sm}, 32'h8);
`endif

    do_pair(32'h7F000000, 32'h3F800000, 0, sm, e);
`ifdef FLOAT_ALIGN_STICKY_EN
    chk("lit029b_sm", {5'd0, sm}, 32'h1);
`else
    chk("lit029b_sm", {5'd0, sm}, 32'h0);
`endif

    // Denormal vs smallest normal, B larger with same effective exponent.
    do_pair(32'h00000001, 32'h00800000, 0, sm, e);
    chk("lit_denorm_e", {24'd0, e}, 32'h01);
    // Special operand skips shifting.
    do_pair(32'h7F800000, 32'h3F800000, 0, sm, e);
    chk("lit_special_sm", {5'd0, sm}, 32'h4000000);
    // Same exponent, B larger fraction, mixed signs.
    do_pair(32'hC0100000, 32'h40200000, 0, sm, e);
    // Backpressure: hold DONE for five cycles.
    do_pair(32'h40000000, 32'h3F800000, 5, sm, e);
    do_pair(32'h41200000, 32'hBE000000, 0, sm, e);

    // Reset in the middle of a long shift.
    @(negedge clk);
    A = 32'h7F000000; B = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_live = 1'b0;
    #1;
    chk("midrst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",   {31'd0, in_ready},  32'd1);
    chk("midrst_small_mant", {5'd0, small_mant}, 32'd0);
    chk("midrst_big_mant",   {8'd0, big_mant},   32'd0);
    chk("midrst_exp_out",    {24'd0, exp_out},   32'd0);
    chk("midrst_signs",      {30'd0, big_sign, small_sign}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("postrst_no_valid", {31'd0, out_valid}, 32'd0);
    do_pair(32'h7F000000, 32'h3F800000, 0, sm, e);
    do_pair(32'h40000000, 32'h3F800000, 0, sm, e);
    chk("lit_post_sm", {5'd0, sm}, 32'h2000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_align.md
FLOAT_ALIGN -- requirements
Module: float_align

Interface
REQ-001 SHALL provide clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL provide rst, input, 1; one clock, reset asynchronous and active-high.
REQ-003 SHALL provide in_valid, input, 1: operand pair A/B presented.
REQ-004 SHALL provide in_ready, output, 1: block accepts a pair this cycle.
REQ-005 SHALL provide A and B, input, 32 each: IEEE-754 single-precision operands.
REQ-006 SHALL provide out_valid, input out_ready, 1 each: result handshake.
REQ-007 SHALL provide big_sign and small_sign, output, 1 each: signs of larger/smaller-magnitude operand.
REQ-008 SHALL provide exp_out, output, 8: effective exponent of larger-magnitude operand.
REQ-009 SHALL provide big_mant, output, 24: {hidden, fraction} of larger operand.
REQ-010 SHALL provide small_mant, output, 27: aligned {hidden, fraction, guard, round, sticky} of smaller operand.
REQ-011 SHALL provide special, output, 1: either operand exponent equals 8'hFF.

Function
REQ-012 SHALL order operands by unsigned magnitude {exp, fraction}; on equal magnitude A is big.
REQ-013 SHALL use hidden bit 1 for exponent != 0; for exponent 0, hidden bit 0 and effective exponent 1.
REQ-014 SHALL run FSM IDLE -> SHIFT -> DONE -> IDLE; in_ready=1 only in IDLE; no overlap of operations.
REQ-015 IDLE, in_valid=1: SHALL capture operands, load small_mant={hidden,frac,3'b000}, diff=big_eff_exp-small_eff_exp, cnt=min(diff,27); go DONE if cnt==0, else SHIFT.
REQ-016 SHIFT: SHALL shift small_mant right one bit per cycle and decrement cnt; go DONE on the cycle cnt reaches 0.
REQ-017 Latency: SHALL assert out_valid exactly 1+min(diff,27) cycles after the accepting edge.
REQ-018 DONE: out_valid=1; all outputs SHALL remain stable until out_valid&&out_ready, then return to IDLE the next cycle.
REQ-019 special=1: SHALL skip shifting (go straight to DONE); outputs carry raw ordered fields.
REQ-020 Outputs SHALL be valid only while out_valid=1; no assertion guarantees on them otherwise.

Reset
REQ-021 rst=1 at any time, including mid-SHIFT, SHALL force IDLE, in_ready=1 after release, out_valid=0, all data outputs and cnt to 0; the in-flight operation is discarded.

Configuration
REQ-022 With FLOAT_ALIGN_STICKY_EN defined, each shift SHALL set bit0 = old bit1 | old bit0 (sticky OR of all bits shifted out).
REQ-023 Without FLOAT_ALIGN_STICKY_EN, each shift SHALL be plain logical right shift; bit0 carries no sticky meaning.

Structure
REQ-024 Shared package SHALL hold field widths (EXP_W=8, FRAC_W=23, EXT_W=27), MAX_SHIFT=27, FSM state encoding.
REQ-025 Magnitude ordering SHALL be a separate combinational sub-module float_mag_order (inputs A,B; outputs swap flag, diff); shifter/FSM in float_align.

Verification
REQ-026 A=0x40000000, B=0x3F800000 -> exp_out=0x80, big_mant=0x800000, small_mant=0x2000000, signs 0/0, out_valid 2 cycles after accept.
REQ-027 A=0x3F800000, B=0xC0000000 -> big_sign=1, small_sign=0, exp_out=0x80, small_mant=0x2000000.
REQ-028 A=B=0x3F800000 -> diff 0, out_valid 1 cycle after accept, small_mant=0x4000000.
REQ-029 A=0x4B000000, B=0x3F800001 -> 23 shifts, small_mant=0x0000009 with macro / 0x0000008 without; A=0x7F000000, B=0x3F800000 -> capped 27 shifts, small_mant=0x1 with macro / 0x0 without, out_valid after 28 cycles.
REQ-030 Hold out_ready=0 five cycles in DONE -> outputs stable, in_ready=0; raise out_ready -> in_ready=1 next cycle, new pair accepted.
REQ-031 Assert rst during SHIFT of REQ-029 pair -> out_valid=0, outputs 0 immediately; after release next pair completes with correct latency.
